// File: rtl/ip_lcd_timer_counter.sv
// HD44780 character-LCD write controller: INIT / SETCURSOR / CMD / DATA with internal cycle timers.
// Define LCD_FAST_SIM_EN to divide every WAIT and POWERUP count by 1000 (TIME_DIV default).
module ip_lcd_timer_counter #(
   parameter int SIZE_DATA = 8,
   parameter int SIZE_FUNC = 4,
`ifdef LCD_FAST_SIM_EN
   parameter int unsigned TIME_DIV = 1000
`else
   parameter int unsigned TIME_DIV = 1
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en_lcd,
   input  logic                 i_lcd_blon,
   input  logic [SIZE_DATA-1:0] i_data,
   input  logic [SIZE_FUNC-1:0] i_func,
   output logic [SIZE_DATA-1:0] o_LCD_DATA,
   output logic                 o_LCD_E,
   output logic                 o_LCD_RW,
   output logic                 o_LCD_RS,
   output logic                 o_LCD_ON,
   output logic                 o_LCD_BLON,
   output logic                 o_done_lcd
);

   localparam int CW = 20;

   function automatic int unsigned scale(input int unsigned n);
      return (n / TIME_DIV == 0) ? 1 : n / TIME_DIV;
   endfunction

   localparam int unsigned T_SETUP   = 2;
   localparam int unsigned T_E_HIGH  = 12;
   localparam int unsigned T_HOLD    = 2;
   localparam int unsigned T_SHORT   = scale(2000);
   localparam int unsigned T_LONG    = scale(82000);
   localparam int unsigned T_INIT1   = T_SHORT + scale(205000);
   localparam int unsigned T_INIT2   = T_SHORT + scale(5000);
   localparam int unsigned T_POWERUP = scale(750000);

   localparam logic [SIZE_FUNC-1:0] FN_INIT   = SIZE_FUNC'(0);
   localparam logic [SIZE_FUNC-1:0] FN_SETCUR = SIZE_FUNC'(1);
   localparam logic [SIZE_FUNC-1:0] FN_DATA   = SIZE_FUNC'(3);
   localparam logic [SIZE_FUNC-1:0] FN_LIMIT  = SIZE_FUNC'(4);
   localparam logic [3:0]           LAST_STEP = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE, S_POWERUP, S_SETUP, S_E_HIGH, S_HOLD, S_WAIT, S_DONE
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic                 init_q;
   logic [3:0]           step;
   logic [SIZE_DATA-1:0] req_byte;
   logic [CW-1:0]        wait_cycles;

   function automatic logic [7:0] init_byte(input logic [3:0] s);
      case (s)
         4'd0, 4'd1, 4'd2, 4'd3: return 8'h38;
         4'd4:                   return 8'h08;
         4'd5:                   return 8'h01;
         4'd6:                   return 8'h06;
         4'd7:                   return 8'h0C;
         default:                return 8'h80;
      endcase
   endfunction

   assign o_LCD_RW = 1'b0;

   // Cursor position: upper nibble selects the line, lower nibble the column.
   always_comb begin
      req_byte = i_data;
      if (i_func == FN_SETCUR)
         req_byte = (i_data[7:4] == 4'h0) ? SIZE_DATA'({4'h8, i_data[3:0]})
                                          : SIZE_DATA'({4'hC, i_data[3:0]});
   end

   // Clear/home need the long execution time; the first two INIT steps add extra settling.
   always_comb begin
      wait_cycles = CW'(T_SHORT);
      if (o_LCD_DATA >= SIZE_DATA'(1) && o_LCD_DATA <= SIZE_DATA'(3))
         wait_cycles = CW'(T_LONG);
      if (init_q && step == 4'd0)
         wait_cycles = CW'(T_INIT1);
      else if (init_q && step == 4'd1)
         wait_cycles = CW'(T_INIT2);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: all state and registered outputs use non-blocking assignments and clear on reset.
      if (!i_rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         init_q     <= 1'b0;
         step       <= '0;
         o_LCD_DATA <= '0;
         o_LCD_E    <= 1'b0;
         o_LCD_RS   <= 1'b0;
         o_LCD_ON   <= 1'b0;
         o_LCD_BLON <= 1'b0;
         o_done_lcd <= 1'b0;
      end else begin
         o_LCD_ON   <= i_en_lcd;
         o_LCD_BLON <= i_lcd_blon;
         o_done_lcd <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_en_lcd && i_func < FN_LIMIT) begin
                  init_q <= (i_func == FN_INIT);
                  step   <= '0;
                  if (i_func == FN_INIT) begin
                     state <= S_POWERUP;
                     cnt   <= CW'(T_POWERUP - 1);
                  end else begin
                     o_LCD_DATA <= req_byte;
                     o_LCD_RS   <= (i_func == FN_DATA);
                     state      <= S_SETUP;
                     cnt        <= CW'(T_SETUP - 1);
                  end
               end
            end
            S_POWERUP: begin
               if (cnt == '0) begin
                  o_LCD_DATA <= SIZE_DATA'(init_byte(4'd0));
                  o_LCD_RS   <= 1'b0;
                  state      <= S_SETUP;
                  cnt        <= CW'(T_SETUP - 1);
               end else
                  cnt <= cnt - CW'(1);
            end
            S_SETUP: begin
               if (cnt == '0) begin
                  o_LCD_E <= 1'b1;
                  state   <= S_E_HIGH;
                  cnt     <= CW'(T_E_HIGH - 1);
               end else
                  cnt <= cnt - CW'(1);
            end
            S_E_HIGH: begin
               if (cnt == '0) begin
                  o_LCD_E <= 1'b0;
                  state   <= S_HOLD;
                  cnt     <= CW'(T_HOLD - 1);
               end else
                  cnt <= cnt - CW'(1);
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  state <= S_WAIT;
                  cnt   <= wait_cycles - CW'(1);
               end else
                  cnt <= cnt - CW'(1);
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  o_done_lcd <= 1'b1;
                  state      <= S_DONE;
               end else
                  cnt <= cnt - CW'(1);
            end
            S_DONE: begin
               if (init_q && step != LAST_STEP) begin
                  step       <= step + 4'd1;
                  o_LCD_DATA <= SIZE_DATA'(init_byte(step + 4'd1));
                  o_LCD_RS   <= 1'b0;
                  state      <= S_SETUP;
                  cnt        <= CW'(T_SETUP - 1);
               end else begin
                  init_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ip_lcd_timer_counter.sv
// Directed bench for ip_lcd_timer_counter, run with TIME_DIV=1000 (fast-sim timing).
module tb_ip_lcd_timer_counter;

   localparam logic [3:0] FN_INIT = 4'd0, FN_SETCUR = 4'd1, FN_CMD = 4'd2, FN_DATA = 4'd3, FN_NOP = 4'd4;
   localparam int LIMIT = 2000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, blon;
   logic [7:0] data;
   logic [3:0] func;
   logic [7:0] lcd_data;
   logic       lcd_e, lcd_rw, lcd_rs, lcd_on, lcd_blon, done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] func;
      logic [7:0] data;
      logic [7:0] exp_byte;
      logic       exp_rs;
      int         exp_lat;
   } vec_t;

   vec_t vecs[12];

   always #10 clk = ~clk;

   ip_lcd_timer_counter #(.SIZE_DATA(8), .SIZE_FUNC(4), .TIME_DIV(1000)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en_lcd(en), .i_lcd_blon(blon),
      .i_data(data), .i_func(func), .o_LCD_DATA(lcd_data), .o_LCD_E(lcd_e),
      .o_LCD_RW(lcd_rw), .o_LCD_RS(lcd_rs), .o_LCD_ON(lcd_on),
      .o_LCD_BLON(lcd_blon), .o_done_lcd(done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counts clock edges until o_done_lcd is seen; -1 if the budget runs out.
   task automatic wait_done(output int n);
      n = -1;
      for (int k = 1; k <= LIMIT; k++) begin
         @(posedge clk); #1;
         if (done) begin
            n = k;
            return;
         end
      end
   endtask

   initial begin
      int n, e_first, e_width, data_bad, done_k, e_cnt, d_cnt;
      logic [7:0] init_exp[9] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h80};
      int         init_lat[9] = '{973, 24, 19, 19, 19, 99, 19, 19, 19};

      vecs[0]  = '{FN_SETCUR, 8'h00, 8'h80, 1'b0, 19};
      vecs[1]  = '{FN_SETCUR, 8'h0F, 8'h8F, 1'b0, 19};
      vecs[2]  = '{FN_SETCUR, 8'h10, 8'hC0, 1'b0, 19};
      vecs[3]  = '{FN_SETCUR, 8'h1F, 8'hCF, 1'b0, 19};
      vecs[4]  = '{FN_CMD,    8'h01, 8'h01, 1'b0, 99};
      vecs[5]  = '{FN_CMD,    8'h02, 8'h02, 1'b0, 99};
      vecs[6]  = '{FN_CMD,    8'h06, 8'h06, 1'b0, 19};
      vecs[7]  = '{FN_CMD,    8'h08, 8'h08, 1'b0, 19};
      vecs[8]  = '{FN_CMD,    8'h0C, 8'h0C, 1'b0, 19};
      vecs[9]  = '{FN_CMD,    8'h38, 8'h38, 1'b0, 19};
      vecs[10] = '{FN_DATA,   8'h41, 8'h41, 1'b1, 19};
      vecs[11] = '{FN_DATA,   8'h33, 8'h33, 1'b1, 19};

      rst_n = 1'b0; en = 1'b1; blon = 1'b1; data = 8'h00; func = FN_NOP;
      #45;
      check("reset_outputs", {lcd_data, lcd_e, lcd_rw, lcd_rs, lcd_on, lcd_blon, done}, 0);
      @(negedge clk); rst_n = 1'b1;

      // INIT: request held one cycle only; the sequence must still run all nine steps.
      @(posedge clk); #1; func = FN_INIT;
      @(posedge clk); #1; func = FN_NOP;
      for (int s = 0; s < 9; s++) begin
         wait_done(n);
         check($sformatf("init%0d_latency", s + 1), n, init_lat[s]);
         check($sformatf("init%0d_byte", s + 1), lcd_data, init_exp[s]);
         check($sformatf("init%0d_rs_rw", s + 1), {lcd_rs, lcd_rw}, 0);
      end
      check("init_on_blon", {lcd_on, lcd_blon}, 2'b11);

      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1; func = vecs[i].func; data = vecs[i].data;
         wait_done(n);
         func = FN_NOP;
         check($sformatf("vec%0d_latency", i), n, vecs[i].exp_lat);
         check($sformatf("vec%0d_byte", i), lcd_data, vecs[i].exp_byte);
         check($sformatf("vec%0d_rs", i), lcd_rs, vecs[i].exp_rs);
      end

      // DATA 'A': E width, data stability around E, and one-cycle done.
      @(posedge clk); #1; func = FN_DATA; data = 8'h41;
      e_first = -1; e_width = 0; data_bad = 0; done_k = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (k == 1) func = FN_NOP;
         if (lcd_e && e_first < 0) e_first = k;
         if (lcd_e) e_width++;
         if (k <= 16 && (lcd_data !== 8'h41 || lcd_rs !== 1'b1)) data_bad++;
         if (done) begin
            done_k = k;
            break;
         end
      end
      check("data_e_first", e_first, 3);
      check("data_e_width", e_width, 12);
      check("data_stable", data_bad, 0);
      check("data_latency", done_k, 19);
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);

      // Level-sensitive request repeats.
      @(posedge clk); #1; func = FN_CMD; data = 8'h06;
      wait_done(n);
      check("repeat_first", n, 19);
      wait_done(n);
      func = FN_NOP;
      check("repeat_second", n, 20);

      // en falls mid-transaction; input changes are ignored and the transaction still finishes.
      @(posedge clk); #1; func = FN_CMD; data = 8'h0C;
      done_k = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (k == 3) begin
            en = 1'b0; blon = 1'b0; data = 8'hFF; func = FN_DATA;
         end
         if (k == 5) check("off_on_blon", {lcd_on, lcd_blon}, 2'b00);
         if (done) begin
            done_k = k;
            break;
         end
      end
      check("enfall_latency", done_k, 19);
      check("enfall_byte_rs", {lcd_data, lcd_rs}, {8'h0C, 1'b0});
      e_cnt = 0; d_cnt = 0;
      repeat (60) begin
         @(posedge clk); #1;
         e_cnt += int'(lcd_e); d_cnt += int'(done);
      end
      check("disabled_no_activity", e_cnt + d_cnt, 0);
      en = 1'b1; blon = 1'b1; func = FN_NOP;
      repeat (2) @(posedge clk);
      #1;
      check("restore_on_blon", {lcd_on, lcd_blon}, 2'b11);

      // Unsupported function code: nothing happens.
      func = 4'd4;
      e_cnt = 0; d_cnt = 0;
      repeat (100) begin
         @(posedge clk); #1;
         e_cnt += int'(lcd_e); d_cnt += int'(done);
      end
      check("nop_no_e", e_cnt, 0);
      check("nop_no_done", d_cnt, 0);

      // Asynchronous reset in the middle of a long WAIT.
      @(posedge clk); #1; func = FN_CMD; data = 8'h01;
      repeat (40) @(posedge clk);
      #1;
      check("pre_reset_state", {lcd_data, lcd_on}, {8'h01, 1'b1});
      func = FN_NOP;
      #4; rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {lcd_data, lcd_e, lcd_rw, lcd_rs, lcd_on, lcd_blon, done}, 0);
      @(negedge clk); rst_n = 1'b1;
      d_cnt = 0; e_cnt = 0;
      repeat (150) begin
         @(posedge clk); #1;
         e_cnt += int'(lcd_e); d_cnt += int'(done);
      end
      check("post_reset_idle", e_cnt + d_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
